// File: rtl/cu_defs.sv
// rtl/cu_defs.sv - shared state encodings, opcode constants and Bicc evaluation for control_sequencer
package cu_defs;

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_FETCH_A = 4'd1,
        ST_FETCH_W = 4'd2,
        ST_FETCH_I = 4'd3,
        ST_DECODE  = 4'd4,
        ST_EXEC    = 4'd5,
        ST_MEM_A   = 4'd6,
        ST_MEM_W   = 4'd7,
        ST_MEM_WB  = 4'd8,
        ST_CALL    = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_NEXT    = 4'd11,
        ST_TRAP_S  = 4'd12
    } state_t;

    // IR[31:30] instruction groups
    localparam logic [1:0] OP_FMT2 = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_MEM  = 2'b11;

    // IR[24:22] within format 2
    localparam logic [2:0] OP2_BICC = 3'b010;

    localparam logic [5:0] OP3_LD  = 6'b000000;
    localparam logic [5:0] OP3_ADD = 6'b000000;

    // Opcodes forced onto the ALU/RAM when the OP1 path is selected
    localparam logic [5:0] OP1_LD_WORD = OP3_LD;
    localparam logic [5:0] OP1_ADD     = OP3_ADD;

    // Bit positions inside REG_LE = {IRE,MDRE,MARE,PCE,nPCE,PSRE,RFE,TBRE}
    localparam int LE_IRE  = 7;
    localparam int LE_MDRE = 6;
    localparam int LE_MARE = 5;
    localparam int LE_PCE  = 4;
    localparam int LE_NPCE = 3;
    localparam int LE_PSRE = 2;
    localparam int LE_RFE  = 1;
    localparam int LE_TBRE = 0;

    localparam logic [1:0] ALU_RS2     = 2'b00;
    localparam logic [1:0] ALU_SIMM13  = 2'b01;
    localparam logic [1:0] RC_RD       = 2'b00;
    localparam logic [1:0] RC_R15      = 2'b11;
    localparam logic [1:0] CIN_PC      = 2'b00;
    localparam logic [1:0] CIN_ALU     = 2'b10;
    localparam logic [1:0] CIN_MDR     = 2'b11;
    localparam logic [1:0] MAR_ALU     = 2'b00;
    localparam logic [1:0] MAR_PC      = 2'b01;
    localparam logic [1:0] MDR_RAM     = 2'b00;
    localparam logic [1:0] MDR_RFA     = 2'b01;
    localparam logic [1:0] NPC_SEL_INC = 2'b00;
    localparam logic [1:0] NPC_SEL_TBR = 2'b01;
    localparam logic [1:0] NPC_SEL_BR  = 2'b10;

    // Full set of datapath controls, registered as one word
    typedef struct packed {
        logic [7:0] reg_le;
        logic       clr_pc;
        logic       mfa;
        logic       mop_sel;
        logic [5:0] op1;
        logic       aop_sel;
        logic       alue;
        logic [1:0] alu_sel;
        logic       ra_sel;
        logic [1:0] rc_sel;
        logic [1:0] cin_sel;
        logic [1:0] mar_sel;
        logic [1:0] mdr_sel;
        logic [1:0] npc_sel;
        logic       npc_add;
        logic       baux;
        logic       trap;
    } ctl_t;

    // SPARC Bicc condition table; cond[3] inverts the base test (BN<->BA, BE<->BNE, ...)
    function automatic logic bicc_taken(input logic [3:0] cond, input logic [3:0] icc);
        logic n, z, v, c, base;
        {n, z, v, c} = icc;
        case (cond[2:0])
            3'b000:  base = 1'b0;
            3'b001:  base = z;
            3'b010:  base = z | (n ^ v);
            3'b011:  base = n ^ v;
            3'b100:  base = c | z;
            3'b101:  base = c;
            3'b110:  base = n;
            default: base = v;
        endcase
        return cond[3] ? ~base : base;
    endfunction

endpackage

// File: rtl/mfc_watchdog.sv
// rtl/mfc_watchdog.sv - counts memory-wait cycles and flags the last permitted one
module mfc_watchdog #(
    parameter int CNT_W = 4,
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count holds the number of wait cycles already completed, so the LIMIT-th cycle sees LIMIT-1
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // Cleared whenever no wait is in progress; saturates so it can never wrap back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired multi-cycle SPARC control FSM; CU_SINGLE_STEP_EN adds STEP gating
module control_sequencer
    import cu_defs::*;
#(
    parameter int MFC_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Clr,
`ifdef CU_SINGLE_STEP_EN
    input  logic        STEP,
`endif
    input  logic [31:0] IR,
    input  logic [3:0]  ICC,
    input  logic        MFC,
    output logic [7:0]  REG_LE,
    output logic        ClrPC,
    output logic        IRClr,
    output logic        MFA,
    output logic        MOP_SEL,
    output logic [5:0]  OP1,
    output logic        AOP_SEL,
    output logic        ALUE,
    output logic [1:0]  ALU_SEL,
    output logic        RA_SEL,
    output logic [1:0]  RC_SEL,
    output logic [1:0]  CIN_SEL,
    output logic [1:0]  MAR_SEL,
    output logic [1:0]  MDR_SEL,
    output logic [1:0]  nPC_SEL,
    output logic        nPC_ADD,
    output logic        BAUX,
    output logic        TRAP,
    output logic [3:0]  STATE
);

    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d;
    logic   taken_q, taken_d;
    logic   fetch_go;
    logic   expired;
    logic   wd_clear;
    logic   is_store;
    logic   unused_ir_bits;

`ifdef CU_SINGLE_STEP_EN
    logic   armed_q, armed_d;
`endif

    assign is_store       = IR[21];
    assign unused_ir_bits = ^{IR[29], IR[20:14], IR[12:0]};
    assign wd_clear       = ~ctl_q.mfa;

    mfc_watchdog #(
        .CNT_W (CNT_W),
        .LIMIT (MFC_TIMEOUT)
    ) u_watchdog (
        .clk     (Clk),
        .rst_n   (Clr),
        .clear   (wd_clear),
        .enable  (ctl_q.mfa),
        .expired (expired)
    );

    // Next state, then the control word for that state so outputs are registered alongside it
    always_comb begin
        state_d  = state_q;
        taken_d  = taken_q;
        fetch_go = 1'b1;
        ctl_d    = '0;
        ctl_d.clr_pc = 1'b1;
`ifdef CU_SINGLE_STEP_EN
        armed_d  = armed_q;
`endif

        case (state_q)
            ST_RESET:   state_d = ST_FETCH_A;
            ST_FETCH_A: begin
`ifdef CU_SINGLE_STEP_EN
                // Idle until STEP, then one more FETCH_A cycle that actually loads MAR
                if (armed_q) begin
                    state_d = ST_FETCH_W;
                    armed_d = 1'b0;
                end else begin
                    armed_d = STEP;
                end
`else
                state_d = ST_FETCH_W;
`endif
            end
            ST_FETCH_W: begin
                if (MFC)          state_d = ST_FETCH_I;
                else if (expired) state_d = ST_TRAP_S;
            end
            ST_FETCH_I: state_d = ST_DECODE;
            ST_DECODE: begin
                case (IR[31:30])
                    OP_ALU:  state_d = ST_EXEC;
                    OP_MEM:  state_d = ST_MEM_A;
                    OP_CALL: state_d = ST_CALL;
                    default: begin
                        if (IR[24:22] == OP2_BICC) begin
                            state_d = ST_BRANCH;
                            taken_d = bicc_taken(IR[28:25], ICC);
                        end else begin
                            state_d = ST_TRAP_S;
                        end
                    end
                endcase
            end
            ST_EXEC:    state_d = ST_NEXT;
            ST_MEM_A:   state_d = ST_MEM_W;
            ST_MEM_W: begin
                if (MFC)          state_d = is_store ? ST_NEXT : ST_MEM_WB;
                else if (expired) state_d = ST_TRAP_S;
            end
            ST_MEM_WB:  state_d = ST_NEXT;
            ST_CALL:    state_d = ST_FETCH_A;
            ST_BRANCH:  state_d = taken_q ? ST_FETCH_A : ST_NEXT;
            ST_NEXT:    state_d = ST_FETCH_A;
            ST_TRAP_S:  state_d = ST_NEXT;
            default:    state_d = ST_RESET;
        endcase

`ifdef CU_SINGLE_STEP_EN
        fetch_go = armed_d;
`endif

        case (state_d)
            ST_RESET: ctl_d.clr_pc = 1'b0;
            ST_FETCH_A: begin
                if (fetch_go) begin
                    ctl_d.reg_le[LE_MARE] = 1'b1;
                    ctl_d.mar_sel         = MAR_PC;
                end
            end
            ST_FETCH_W: begin
                ctl_d.mfa             = 1'b1;
                ctl_d.mop_sel         = 1'b1;
                ctl_d.op1             = OP1_LD_WORD;
                ctl_d.mdr_sel         = MDR_RAM;
                ctl_d.reg_le[LE_MDRE] = 1'b1;
            end
            ST_FETCH_I: ctl_d.reg_le[LE_IRE] = 1'b1;
            ST_EXEC: begin
                ctl_d.alue            = 1'b1;
                ctl_d.reg_le[LE_RFE]  = 1'b1;
                ctl_d.reg_le[LE_PSRE] = 1'b1;
                ctl_d.cin_sel         = CIN_ALU;
                ctl_d.rc_sel          = RC_RD;
                ctl_d.alu_sel         = IR[13] ? ALU_SIMM13 : ALU_RS2;
            end
            ST_MEM_A: begin
                ctl_d.aop_sel         = 1'b1;
                ctl_d.op1             = OP1_ADD;
                ctl_d.alu_sel         = IR[13] ? ALU_SIMM13 : ALU_RS2;
                ctl_d.mar_sel         = MAR_ALU;
                ctl_d.reg_le[LE_MARE] = 1'b1;
                // A store captures rd into MDR while the address is being formed
                if (is_store) begin
                    ctl_d.mdr_sel         = MDR_RFA;
                    ctl_d.ra_sel          = 1'b1;
                    ctl_d.reg_le[LE_MDRE] = 1'b1;
                end
            end
            ST_MEM_W: begin
                ctl_d.mfa = 1'b1;
                if (is_store) begin
                    ctl_d.mdr_sel = MDR_RFA;
                    ctl_d.ra_sel  = 1'b1;
                end else begin
                    ctl_d.mdr_sel         = MDR_RAM;
                    ctl_d.reg_le[LE_MDRE] = 1'b1;
                end
            end
            ST_MEM_WB: begin
                ctl_d.reg_le[LE_RFE] = 1'b1;
                ctl_d.cin_sel        = CIN_MDR;
                ctl_d.rc_sel         = RC_RD;
            end
            ST_CALL: begin
                ctl_d.reg_le[LE_RFE]  = 1'b1;
                ctl_d.rc_sel          = RC_R15;
                ctl_d.cin_sel         = CIN_PC;
                ctl_d.reg_le[LE_PCE]  = 1'b1;
                ctl_d.reg_le[LE_NPCE] = 1'b1;
                ctl_d.npc_sel         = NPC_SEL_BR;
                ctl_d.baux            = 1'b1;
            end
            ST_BRANCH: begin
                if (taken_d) begin
                    ctl_d.reg_le[LE_PCE]  = 1'b1;
                    ctl_d.reg_le[LE_NPCE] = 1'b1;
                    ctl_d.npc_sel         = NPC_SEL_BR;
                    ctl_d.baux            = 1'b1;
                end
            end
            ST_NEXT: begin
                ctl_d.reg_le[LE_PCE]  = 1'b1;
                ctl_d.reg_le[LE_NPCE] = 1'b1;
                ctl_d.npc_sel         = NPC_SEL_INC;
                ctl_d.npc_add         = 1'b1;
            end
            ST_TRAP_S: begin
                ctl_d.trap            = 1'b1;
                ctl_d.reg_le[LE_TBRE] = 1'b1;
                ctl_d.reg_le[LE_NPCE] = 1'b1;
                ctl_d.npc_sel         = NPC_SEL_TBR;
            end
            default: ctl_d.clr_pc = 1'b1;
        endcase
    end

    // State register and registered control word; reset forces everything low at once
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= ST_RESET;
            ctl_q   <= '0;
            taken_q <= 1'b0;
`ifdef CU_SINGLE_STEP_EN
            armed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            taken_q <= taken_d;
`ifdef CU_SINGLE_STEP_EN
            armed_q <= armed_d;
`endif
        end
    end

    assign REG_LE  = ctl_q.reg_le;
    assign ClrPC   = ctl_q.clr_pc;
    assign IRClr   = ctl_q.clr_pc;
    assign MFA     = ctl_q.mfa;
    assign MOP_SEL = ctl_q.mop_sel;
    assign OP1     = ctl_q.op1;
    assign AOP_SEL = ctl_q.aop_sel;
    assign ALUE    = ctl_q.alue;
    assign ALU_SEL = ctl_q.alu_sel;
    assign RA_SEL  = ctl_q.ra_sel;
    assign RC_SEL  = ctl_q.rc_sel;
    assign CIN_SEL = ctl_q.cin_sel;
    assign MAR_SEL = ctl_q.mar_sel;
    assign MDR_SEL = ctl_q.mdr_sel;
    assign nPC_SEL = ctl_q.npc_sel;
    assign nPC_ADD = ctl_q.npc_add;
    assign BAUX    = ctl_q.baux;
    assign TRAP    = ctl_q.trap;
    assign STATE   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic [3:0]  icc;
    logic        mfc;
`ifdef CU_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic [7:0]  reg_le;
    logic        clr_pc, ir_clr, mfa, mop_sel, aop_sel, alue, ra_sel, npc_add, baux, trap;
    logic [5:0]  op1;
    logic [1:0]  alu_sel, rc_sel, cin_sel, mar_sel, mdr_sel, npc_sel;
    logic [3:0]  state;

    int tests     = 0;
    int failed    = 0;
    int ire_count = 0;
    int wait_ok;

    localparam int S_RESET = 0, S_FETCH_A = 1, S_FETCH_W = 2, S_FETCH_I = 3, S_DECODE = 4;
    localparam int S_EXEC = 5, S_MEM_A = 6, S_MEM_W = 7, S_MEM_WB = 8, S_CALL = 9;
    localparam int S_BRANCH = 10, S_NEXT = 11, S_TRAP_S = 12;

    control_sequencer dut (
        .Clk     (clk),
        .Clr     (clr),
`ifdef CU_SINGLE_STEP_EN
        .STEP    (step),
`endif
        .IR      (ir),
        .ICC     (icc),
        .MFC     (mfc),
        .REG_LE  (reg_le),
        .ClrPC   (clr_pc),
        .IRClr   (ir_clr),
        .MFA     (mfa),
        .MOP_SEL (mop_sel),
        .OP1     (op1),
        .AOP_SEL (aop_sel),
        .ALUE    (alue),
        .ALU_SEL (alu_sel),
        .RA_SEL  (ra_sel),
        .RC_SEL  (rc_sel),
        .CIN_SEL (cin_sel),
        .MAR_SEL (mar_sel),
        .MDR_SEL (mdr_sel),
        .nPC_SEL (npc_sel),
        .nPC_ADD (npc_add),
        .BAUX    (baux),
        .TRAP    (trap),
        .STATE   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (reg_le[7]) ire_count++;
    endtask

    // From FETCH_A with prompt MFC: FETCH_W, FETCH_I, DECODE
    task automatic fetch(input logic [31:0] instr);
        ir  = instr;
        mfc = 1'b1;
        tick();
        tick();
        mfc = 1'b0;
        tick();
        check("fetch_to_decode", 32'(state), S_DECODE);
    endtask

    initial begin
        clr = 1'b0;
        ir  = 32'h0;
        icc = 4'h0;
        mfc = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state), S_RESET);
        check("rst_reg_le", 32'(reg_le), 0);
        check("rst_clrpc", 32'(clr_pc), 0);
        check("rst_irclr", 32'(ir_clr), 0);
        check("rst_mfa", 32'(mfa), 0);
        check("rst_trap", 32'(trap), 0);

        // Fetch with MFC returned two cycles after MFA rises
        clr = 1'b1;
        ir  = 32'h82004002;
        tick();
        check("fa_state", 32'(state), S_FETCH_A);
        check("fa_reg_le", 32'(reg_le), 32'h20);
        check("fa_mar_sel", 32'(mar_sel), 1);
        check("fa_clrpc", 32'(clr_pc), 1);
        tick();
        check("fw1_state", 32'(state), S_FETCH_W);
        check("fw1_mfa", 32'(mfa), 1);
        check("fw1_reg_le", 32'(reg_le), 32'h40);
        check("fw1_mop_sel", 32'(mop_sel), 1);
        tick();
        check("fw2_state", 32'(state), S_FETCH_W);
        tick();
        check("fw3_state", 32'(state), S_FETCH_W);
        mfc = 1'b1;
        tick();
        mfc = 1'b0;
        check("fi_state", 32'(state), S_FETCH_I);
        check("fi_reg_le", 32'(reg_le), 32'h80);
        tick();
        check("dec_state", 32'(state), S_DECODE);
        check("dec_reg_le", 32'(reg_le), 0);
        check("ire_once", 32'(ire_count), 1);

        // add r1,r2,r1
        tick();
        check("exec_state", 32'(state), S_EXEC);
        check("exec_alu_sel", 32'(alu_sel), 0);
        check("exec_reg_le", 32'(reg_le), 32'h06);
        check("exec_alue", 32'(alue), 1);
        check("exec_cin_sel", 32'(cin_sel), 2);
        tick();
        check("next_state", 32'(state), S_NEXT);
        check("next_npc_add", 32'(npc_add), 1);
        check("next_reg_le", 32'(reg_le), 32'h18);
        tick();
        check("alu_back_fa", 32'(state), S_FETCH_A);

        // ld [r1+4],r1
        fetch(32'hC2006004);
        tick();
        check("ld_mema_state", 32'(state), S_MEM_A);
        check("ld_mema_aop", 32'(aop_sel), 1);
        check("ld_mema_alu_sel", 32'(alu_sel), 1);
        check("ld_mema_reg_le", 32'(reg_le), 32'h20);
        tick();
        check("ld_memw_state", 32'(state), S_MEM_W);
        check("ld_memw_mfa", 32'(mfa), 1);
        check("ld_memw_mop_sel", 32'(mop_sel), 0);
        check("ld_memw_reg_le", 32'(reg_le), 32'h40);
        mfc = 1'b1;
        tick();
        mfc = 1'b0;
        check("ld_wb_state", 32'(state), S_MEM_WB);
        check("ld_wb_cin_sel", 32'(cin_sel), 3);
        check("ld_wb_reg_le", 32'(reg_le), 32'h02);
        tick();
        check("ld_next", 32'(state), S_NEXT);
        tick();

        // st r1,[r1+4]
        fetch(32'hC2206004);
        tick();
        check("st_mema_reg_le", 32'(reg_le), 32'h60);
        check("st_mema_mdr_sel", 32'(mdr_sel), 1);
        check("st_mema_ra_sel", 32'(ra_sel), 1);
        tick();
        check("st_memw_state", 32'(state), S_MEM_W);
        mfc = 1'b1;
        tick();
        mfc = 1'b0;
        check("st_skip_wb", 32'(state), S_NEXT);
        tick();

        // be, taken
        icc = 4'b0100;
        fetch(32'h02800003);
        tick();
        check("be_t_state", 32'(state), S_BRANCH);
        check("be_t_npc_sel", 32'(npc_sel), 2);
        check("be_t_baux", 32'(baux), 1);
        tick();
        check("be_t_to_fa", 32'(state), S_FETCH_A);

        // be, not taken
        icc = 4'b0000;
        fetch(32'h02800003);
        tick();
        check("be_n_npc_sel", 32'(npc_sel), 0);
        check("be_n_baux", 32'(baux), 0);
        tick();
        check("be_n_next", 32'(state), S_NEXT);
        tick();

        // call
        fetch(32'h40000010);
        tick();
        check("call_state", 32'(state), S_CALL);
        check("call_rc_sel", 32'(rc_sel), 3);
        check("call_reg_le", 32'(reg_le), 32'h1A);
        tick();
        check("call_to_fa", 32'(state), S_FETCH_A);

        // unimplemented format-2 word traps
        fetch(32'h00000000);
        tick();
        check("illegal_state", 32'(state), S_TRAP_S);
        check("illegal_reg_le", 32'(reg_le), 32'h09);
        tick();
        tick();

        // MFC never returns: 15 FETCH_W cycles, then trap
        wait_ok = 1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (state != 4'(S_FETCH_W) || trap !== 1'b0) wait_ok = 0;
        end
        check("to_wait_15", 32'(wait_ok), 1);
        tick();
        check("to_trap_state", 32'(state), S_TRAP_S);
        check("to_trap_pulse", 32'(trap), 1);
        check("to_npc_sel", 32'(npc_sel), 1);
        tick();
        check("to_trap_drop", 32'(trap), 0);
        check("to_next", 32'(state), S_NEXT);
        tick();

        // MFC on the 15th cycle wins
        ir = 32'hC2006004;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 15) mfc = 1'b1;
        end
        tick();
        mfc = 1'b0;
        check("lim_no_trap_state", 32'(state), S_FETCH_I);
        check("lim_no_trap", 32'(trap), 0);

        // Reset in the middle of a memory wait
        tick();
        tick();
        tick();
        check("mid_memw", 32'(state), S_MEM_W);
        #2 clr = 1'b0;
        #1;
        check("mid_rst_mfa", 32'(mfa), 0);
        check("mid_rst_state", 32'(state), S_RESET);
        @(negedge clk);
        clr = 1'b1;
        tick();
        check("restart_fa", 32'(state), S_FETCH_A);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
